// File: rtl/callret_pkg.sv
// Shared types and defaults for the CALL/RET stack initiator.
// FSM encoding is fixed so that state can be probed by debug logic.
package callret_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int WIDTH_DATA_DEF = 32;
  localparam int DEPTH_DEF      = 10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PUSH = 3'd1,
    S_POP  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/call_ret_ctrl.sv
// CALL/RET controller: drives push/pop strobes into an external LIFO stack.
// Optional macro CALLRET_DEPTH_EN adds a local occupancy counter (depth_count).
module call_ret_ctrl
  import callret_pkg::*;
#(
  parameter int WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_req,
  input  logic                  ret_req,
  input  logic [ADDR_W-1:0]     pc_in,
  input  logic                  err_clr,
  output logic                  ready,
  output logic                  done,
  output logic                  ret_valid,
  output logic [ADDR_W-1:0]     ret_addr,
  output logic                  overflow_err,
  output logic                  underflow_err,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [WIDTH_DATA-1:0] stk_data_in,
  input  logic [WIDTH_DATA-1:0] stk_data_out,
  input  logic                  stk_full,
  input  logic                  stk_empty,
  output logic [CNT_W-1:0]      depth_count
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] push_addr;
  logic              is_ret;
  logic              acc_call, acc_ret, set_ovf, set_unf, clr_err;
  logic              full_eff, empty_eff;

  // Only the low ADDR_W bits of the stack word carry a return address.
  logic unused_data;
  assign unused_data = ^stk_data_out;

`ifdef CALLRET_DEPTH_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == S_PUSH && cnt != CNT_W'(DEPTH)) begin
      cnt <= cnt + CNT_W'(1);
    end else if (state == S_POP && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign full_eff    = stk_full  || (cnt == CNT_W'(DEPTH));
  assign empty_eff   = stk_empty || (cnt == '0);
  assign depth_count = cnt;
`else
  assign full_eff    = stk_full;
  assign empty_eff   = stk_empty;
  assign depth_count = '0;
`endif

  always_comb begin
    state_n  = state;
    acc_call = 1'b0;
    acc_ret  = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    clr_err  = 1'b0;
    case (state)
      S_IDLE: begin
        // RET wins a tie; the losing CALL is simply dropped.
        if (ret_req) begin
          if (empty_eff) begin
            set_unf = 1'b1;
            state_n = S_ERR;
          end else begin
            acc_ret = 1'b1;
            state_n = S_POP;
          end
        end else if (call_req) begin
          if (full_eff) begin
            set_ovf = 1'b1;
            state_n = S_ERR;
          end else begin
            acc_call = 1'b1;
            state_n  = S_PUSH;
          end
        end
      end
      S_PUSH, S_POP: state_n = S_DONE;
      S_DONE:        state_n = S_IDLE;
      S_ERR: begin
        if (err_clr) begin
          clr_err = 1'b1;
          state_n = S_IDLE;
        end
      end
      default:       state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      push_addr     <= '0;
      is_ret        <= 1'b0;
      ret_addr      <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      state <= state_n;
      if (acc_call) begin
        push_addr <= pc_in + ADDR_W'(1);
        is_ret    <= 1'b0;
      end
      if (acc_ret) begin
        ret_addr <= stk_data_out[ADDR_W-1:0];
        is_ret   <= 1'b1;
      end
      if (clr_err) begin
        overflow_err  <= 1'b0;
        underflow_err <= 1'b0;
      end else begin
        if (set_ovf) overflow_err  <= 1'b1;
        if (set_unf) underflow_err <= 1'b1;
      end
    end
  end

  // All outputs decode from registered state, so nothing is combinational from inputs.
  assign ready       = (state == S_IDLE);
  assign stk_push    = (state == S_PUSH);
  assign stk_pop     = (state == S_POP);
  assign done        = (state == S_DONE);
  assign ret_valid   = (state == S_DONE) && is_ret;
  assign stk_data_in = stk_push ? WIDTH_DATA'(push_addr) : '0;

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Scoreboard bench for call_ret_ctrl with a behavioural LIFO as responder.
module tb_call_ret_ctrl;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int DEPTH = 10;
  localparam int CW = $clog2(DEPTH + 1);

  localparam int K_PUSH = 0, K_POP = 1, K_DCALL = 2, K_DRET = 3, K_OVF = 4, K_UNF = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          call_req = 1'b0, ret_req = 1'b0, err_clr = 1'b0;
  logic [AW-1:0] pc_in = '0;
  logic          ready, done, ret_valid, overflow_err, underflow_err, stk_push, stk_pop;
  logic [AW-1:0] ret_addr;
  logic [DW-1:0] stk_data_in, stk_data_out;
  logic          stk_full, stk_empty;
  logic [CW-1:0] depth_count;

  call_ret_ctrl dut (
    .clk(clk), .reset(reset), .call_req(call_req), .ret_req(ret_req), .pc_in(pc_in),
    .err_clr(err_clr), .ready(ready), .done(done), .ret_valid(ret_valid),
    .ret_addr(ret_addr), .overflow_err(overflow_err), .underflow_err(underflow_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out), .stk_full(stk_full), .stk_empty(stk_empty),
    .depth_count(depth_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: a plain LIFO sharing the controller's reset.
  logic [DW-1:0] smem [DEPTH];
  int            scnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) scnt <= 0;
    else if (stk_push && scnt < DEPTH) begin
      smem[scnt] <= stk_data_in;
      scnt       <= scnt + 1;
    end else if (stk_pop && scnt > 0) scnt <= scnt - 1;
  end
  always_comb begin
    stk_data_out = '0;
    if (scnt > 0) stk_data_out = smem[scnt-1];
  end
  assign stk_full  = (scnt == DEPTH);
  assign stk_empty = (scnt == 0);

  int errors = 0;
  int checks = 0;

  function automatic void ck(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {int kind; int cyc; logic [AW-1:0] addr;} ev_t;
  ev_t           exp_q [$];
  logic [AW-1:0] ref_stk [$];

  function automatic void push_exp(int kind, int c, logic [AW-1:0] a);
    ev_t e;
    e.kind = kind; e.cyc = c; e.addr = a;
    exp_q.push_back(e);
  endfunction

  function automatic void match(int kind, logic [DW-1:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    ck("event_kind", kind, e.kind);
    ck("event_cycle", cyc, e.cyc);
    if (kind == K_PUSH) ck("push_data", data, {16'h0, e.addr});
    if (kind == K_DRET) ck("ret_addr", data, {16'h0, e.addr});
  endfunction

  // Monitor: turns DUT activity into events and checks them against the queue.
  logic prev_ovf = 1'b0, prev_unf = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_ovf <= 1'b0;
      prev_unf <= 1'b0;
    end else begin
      ck("strobe_excl", stk_push & stk_pop, 0);
      ck("ret_valid_only_in_done", ret_valid & ~done, 0);
      if (!stk_push) ck("data_in_zero", stk_data_in, 0);
      if (stk_push) match(K_PUSH, stk_data_in);
      if (stk_pop) match(K_POP, '0);
      if (done) begin
        match(ret_valid ? K_DRET : K_DCALL, {16'h0, ret_addr});
`ifdef CALLRET_DEPTH_EN
        ck("depth_count", depth_count, ref_stk.size());
`else
        ck("depth_count", depth_count, 0);
`endif
      end
      if (overflow_err && !prev_ovf) match(K_OVF, '0);
      if (underflow_err && !prev_unf) match(K_UNF, '0);
      prev_ovf <= overflow_err;
      prev_unf <= underflow_err;
    end
  end

  task automatic idle_in();
    call_req = 1'b0; ret_req = 1'b0; err_clr = 1'b0;
  endtask

  // Requests while busy must be ignored.
  task automatic junk(input bit allow_clr);
    call_req = 1'($urandom); ret_req = 1'($urandom); pc_in = 16'($urandom);
    err_clr  = allow_clr ? 1'($urandom) : 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin @(negedge clk); n++; end
    if (!ready) ck("ready_timeout", ready, 1);
  endtask

  task automatic do_op(input bit c, input bit r, input logic [AW-1:0] pc);
    int a;
    bit er;
    logic [AW-1:0] v;
    er = 1'b0;
    wait_ready();
    call_req = c; ret_req = r; pc_in = pc; err_clr = 1'b0;
    a = cyc + 1;
    if (r) begin
      if (ref_stk.size() == 0) begin
        push_exp(K_UNF, a, '0); er = 1'b1;
      end else begin
        v = ref_stk.pop_back();
        push_exp(K_POP, a, '0); push_exp(K_DRET, a + 1, v);
      end
    end else if (c) begin
      if (ref_stk.size() == DEPTH) begin
        push_exp(K_OVF, a, '0); er = 1'b1;
      end else begin
        v = pc + 16'd1;
        ref_stk.push_back(v);
        push_exp(K_PUSH, a, v); push_exp(K_DCALL, a + 1, '0);
      end
    end else begin
      @(negedge clk);
      return;
    end
    @(negedge clk);
    if (er) begin
      junk(1'b0);
      ck("err_ready_low", ready, 0);
      ck("err_flags", {overflow_err, underflow_err}, r ? 2'b01 : 2'b10);
      repeat ($urandom_range(0, 2)) begin @(negedge clk); junk(1'b0); end
      junk(1'b0); err_clr = 1'b1;
      @(negedge clk); idle_in();
      ck("err_cleared", {ready, overflow_err, underflow_err}, 3'b100);
    end else begin
      junk(1'b1);
      ck("busy_ready_low", ready, 0);
      @(negedge clk); junk(1'b1);
      @(negedge clk); idle_in();
      ck("ready_at_n3", ready, 1);
    end
  endtask

  initial begin
    int r;
    repeat (3) @(negedge clk);
    ck("rst_ready", ready, 1);
    ck("rst_outs", {done, ret_valid, overflow_err, underflow_err, stk_push, stk_pop}, 0);
    ck("rst_ret_addr", ret_addr, 0);
    ck("rst_data_in", stk_data_in, 0);
    ck("rst_depth", depth_count, 0);
    reset = 1'b1;
    @(negedge clk);

    do_op(1, 0, 16'h0010);
    do_op(0, 1, 16'h0);
    ck("single_ret_addr", ret_addr, 16'h0011);

    do_op(1, 0, 16'h0100); do_op(1, 0, 16'h0200); do_op(1, 0, 16'h0300);
    for (int i = 0; i < 3; i++) do_op(0, 1, 16'h0);
    ck("nested_last_addr", ret_addr, 16'h0101);
    ck("nested_empty", stk_empty, 1);

    do_op(0, 1, 16'h0);
    ck("underflow_keeps_addr", ret_addr, 16'h0101);

    for (int i = 1; i <= DEPTH + 1; i++) do_op(1, 0, 16'(i * 16));
    do_op(0, 1, 16'h0);
    ck("overflow_then_ret", ret_addr, 16'h00A1);
    for (int i = 0; i < DEPTH - 1; i++) do_op(0, 1, 16'h0);

    do_op(1, 0, 16'h0040);
    do_op(1, 1, 16'h0055);
    ck("tie_ret_wins", ret_addr, 16'h0041);
    ck("tie_stack_empty", stk_empty, 1);

    do_op(1, 0, 16'hFFFF);
    do_op(0, 1, 16'h0);
    ck("wrap_ret_addr", ret_addr, 16'h0000);

    // Abort a CALL while its push strobe is up.
    do_op(1, 0, 16'h0700);
    wait_ready();
    call_req = 1'b1; pc_in = 16'h1234;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    ck("midrst_push", stk_push, 0);
    ck("midrst_ready", ready, 1);
    ck("midrst_outs", {done, ret_valid, overflow_err, underflow_err, stk_pop}, 0);
    ck("midrst_ret_addr", ret_addr, 0);
    ck("midrst_depth", depth_count, 0);
    idle_in();
    exp_q.delete();
    ref_stk.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ck("post_release_strobes", {stk_push, stk_pop}, 0);
    ck("post_release_ready", ready, 1);
    do_op(0, 1, 16'h0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      do_op(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, 16'($urandom));
    end
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      do_op(r < 6 || r == 8, (r >= 6 && r < 8) || r == 8, 16'($urandom));
    end

    repeat (4) @(negedge clk);
    ck("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
